cbus_arbiter_rr: RTL and testbench

- N-input CBus arbiter between the bus converters (instruction, data, and future page-walker/DMA masters) and the single external CBus port.
- Grants one requester at a time and holds the grant for the full (possibly burst) transaction.
- Routes the response back only to the granted requester.
- Supports round-robin or fixed-priority selection, reports the current grant, and flags requesters that abandon a transaction mid-burst.

---
 rtl/cbus_arbiter_rr_pkg.sv | 37 +++
 rtl/cbus_rr_pick.sv | 33 +++
 rtl/cbus_arbiter_rr.sv | 106 ++++++++++
 tb/tb_cbus_arbiter_rr.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cbus_arbiter_rr_pkg.sv
// Shared CBus types and arbiter policy constants used by the bus converters and arbiters.
package cbus_arbiter_rr_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  localparam int CBUS_ADDR_W = 32;
  localparam int CBUS_DATA_W = 32;
  localparam int CBUS_STRB_W = CBUS_DATA_W / 8;
  localparam int CBUS_LEN_W  = 8;

  // len counts beats minus one, so len=0 is a single-beat transfer.
  typedef struct packed {
    logic                   valid;
    logic                   we;
    logic [CBUS_ADDR_W-1:0] addr;
    logic [CBUS_DATA_W-1:0] wdata;
    logic [CBUS_STRB_W-1:0] wstrb;
    logic [CBUS_LEN_W-1:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic                   ready;
    logic                   last;
    logic                   err;
    logic [CBUS_DATA_W-1:0] rdata;
  } cbus_resp_t;

  // Adds step to idx modulo n; callers keep idx < n and step <= n.
  function automatic int wrap_inc(input int idx, input int step, input int n);
    int s;
    s = idx + step;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/cbus_rr_pick.sv
// Combinational winner selection over a valid vector: round-robin from ptr, or lowest index first.
module cbus_rr_pick
  import cbus_arbiter_rr_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int MODE   = ARB_RR,
  parameter int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] valid,
  input  logic [IDX_W-1:0]  ptr,
  output logic [IDX_W-1:0]  win_idx,
  output logic              win_valid
);

  // Fixed priority is just a round-robin scan that always starts at channel 0.
  always_comb begin
    int               base;
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    win_idx   = '0;
    win_valid = 1'b0;
    base      = (MODE == ARB_FIXED) ? 0 : int'(ptr);
    for (int k = 0; k < NUM_CH; k++) begin
      cand     = wrap_inc(base, k, NUM_CH);
      cand_idx = IDX_W'(cand);
      if (!win_valid && valid[cand_idx]) begin
        win_valid = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/cbus_arbiter_rr.sv
// N-to-1 CBus arbiter: grants one master per transaction, holds it through the burst, routes the response back.
module cbus_arbiter_rr
  import cbus_arbiter_rr_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int MODE   = ARB_RR,
  parameter int IDX_W  = $clog2(NUM_CH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  cbus_req_t  [NUM_CH-1:0]       ireqs,
  output cbus_resp_t [NUM_CH-1:0]       iresps,
  output cbus_req_t                     oreq,
  input  cbus_resp_t                    oresp,
  output logic [IDX_W-1:0]              grant_idx,
  output logic                          busy,
  output logic                          protocol_err
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [NUM_CH-1:0] req_valid;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_valid;
  logic              gnt_valid;
  logic              done;
  logic              abandon;
  logic [IDX_W-1:0]  next_ptr;

  always_comb begin
    req_valid = '0;
    for (int i = 0; i < NUM_CH; i++) req_valid[i] = ireqs[i].valid;
  end

  cbus_rr_pick #(
    .NUM_CH (NUM_CH),
    .MODE   (MODE),
    .IDX_W  (IDX_W)
  ) u_pick (
    .valid     (req_valid),
    .ptr       (rr_ptr_q),
    .win_idx   (pick_idx),
    .win_valid (pick_valid)
  );

  // Completion wins over abandonment when the master drops valid on its own last beat.
  assign gnt_valid = ireqs[grant_q].valid;
  assign done      = oresp.ready && oresp.last;
  assign abandon   = (state_q == BUSY) && !gnt_valid && !done;
  assign next_ptr  = IDX_W'(wrap_inc(int'(grant_q), 1, NUM_CH));
  assign grant_idx = grant_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = BUSY;
          grant_d = pick_idx;
        end
      end
      BUSY: begin
        if (done || abandon) begin
          state_d = IDLE;
          if (MODE == ARB_RR) rr_ptr_d = next_ptr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Gating on reset drops the grant in the very cycle reset is applied, not one cycle later.
  always_comb begin
    oreq         = '0;
    iresps       = '0;
    busy         = 1'b0;
    protocol_err = 1'b0;
    if (reset && state_q == BUSY) begin
      oreq            = ireqs[grant_q];
      iresps[grant_q] = oresp;
      busy            = 1'b1;
      protocol_err    = abandon;
    end
  end

endmodule

// File: tb/tb_cbus_arbiter_rr.sv
// Directed bench for cbus_arbiter_rr: 2-channel RR, 4-channel RR and 4-channel fixed-priority instances.
module tb_cbus_arbiter_rr;
  import cbus_arbiter_rr_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  cbus_req_t  [1:0] req2;
  cbus_resp_t [1:0] resp2;
  cbus_req_t        oreq2;
  cbus_resp_t       oresp2;
  logic [0:0]       gnt2;
  logic             busy2, err2;

  cbus_req_t  [3:0] req4;
  cbus_resp_t [3:0] resp4;
  cbus_req_t        oreq4;
  cbus_resp_t       oresp4;
  logic [1:0]       gnt4;
  logic             busy4, err4;

  cbus_req_t  [3:0] reqf;
  cbus_resp_t [3:0] respf;
  cbus_req_t        oreqf;
  cbus_resp_t       orespf;
  logic [1:0]       gntf;
  logic             busyf, errf;

  cbus_arbiter_rr #(.NUM_CH(2), .MODE(ARB_RR)) u_rr2 (
    .clk(clk), .reset(reset), .ireqs(req2), .iresps(resp2), .oreq(oreq2), .oresp(oresp2),
    .grant_idx(gnt2), .busy(busy2), .protocol_err(err2)
  );

  cbus_arbiter_rr #(.NUM_CH(4), .MODE(ARB_RR)) u_rr4 (
    .clk(clk), .reset(reset), .ireqs(req4), .iresps(resp4), .oreq(oreq4), .oresp(oresp4),
    .grant_idx(gnt4), .busy(busy4), .protocol_err(err4)
  );

  cbus_arbiter_rr #(.NUM_CH(4), .MODE(ARB_FIXED)) u_fx4 (
    .clk(clk), .reset(reset), .ireqs(reqf), .iresps(respf), .oreq(oreqf), .oresp(orespf),
    .grant_idx(gntf), .busy(busyf), .protocol_err(errf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic cbus_req_t mkreq(input logic [31:0] addr, input logic [7:0] len);
    cbus_req_t r;
    r       = '0;
    r.valid = 1'b1;
    r.addr  = addr;
    r.len   = len;
    return r;
  endfunction

  function automatic cbus_resp_t mkresp(input logic ready, input logic last, input logic [31:0] rdata);
    cbus_resp_t r;
    r       = '0;
    r.ready = ready;
    r.last  = last;
    r.rdata = rdata;
    return r;
  endfunction

  // Advance to just after the next rising edge; inputs are changed here, outputs sampled 1 time unit later.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    int exp_rr [5];
    exp_rr   = '{0, 1, 2, 3, 0};
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    req2 = '0; oresp2 = '0;
    req4 = '0; oresp4 = '0;
    reqf = '0; orespf = '0;

    // Reset state
    repeat (3) applyStimulus();
    #1;
    checkOutput("rst_busy",      64'(busy4), 64'(0));
    checkOutput("rst_oreq_vld",  64'(oreq4.valid), 64'(0));
    checkOutput("rst_grant",     64'(gnt4), 64'(0));
    checkOutput("rst_perr",      64'(err4), 64'(0));
    checkOutput("rst_iresps",    64'(resp4 != '0), 64'(0));
    checkOutput("rst_busy2",     64'(busy2), 64'(0));
    applyStimulus();
    reset = 1'b1;

    // Single-beat read from channel 1 on the 2-channel instance
    req2[1] = mkreq(32'h8000_0000, 8'd0);
    #1;
    checkOutput("t1_idle_busy",  64'(busy2), 64'(0));
    checkOutput("t1_idle_oreq",  64'(oreq2.valid), 64'(0));
    applyStimulus();
    #1;
    checkOutput("t1_busy",       64'(busy2), 64'(1));
    checkOutput("t1_grant",      64'(gnt2), 64'(1));
    checkOutput("t1_oreq_vld",   64'(oreq2.valid), 64'(1));
    checkOutput("t1_oreq_addr",  64'(oreq2.addr), 64'h8000_0000);
    checkOutput("t1_rdy_early",  64'(resp2[1].ready), 64'(0));
    applyStimulus();
    oresp2 = mkresp(1'b1, 1'b1, 32'hCAFE_0001);
    #1;
    checkOutput("t1_rdy",        64'(resp2[1].ready), 64'(1));
    checkOutput("t1_rdata",      64'(resp2[1].rdata), 64'hCAFE_0001);
    checkOutput("t1_other_zero", 64'(resp2[0]), 64'(0));
    applyStimulus();
    req2[0] = mkreq(32'h0000_0100, 8'd0);
    #1;
    checkOutput("t1_after_busy", 64'(busy2), 64'(0));
    checkOutput("t1_after_rdy",  64'(resp2[1].ready), 64'(0));
    applyStimulus();
    #1;
    checkOutput("t1_ptr_zero",   64'(gnt2), 64'(0));
    applyStimulus();
    req2 = '0;
    oresp2 = '0;

    // Fixed priority: channel 1 beats channel 3 until it drops
    reqf[1] = mkreq(32'h0000_1000, 8'd0);
    reqf[3] = mkreq(32'h0000_3000, 8'd0);
    orespf  = mkresp(1'b1, 1'b1, 32'h0);
    for (int n = 0; n < 3; n++) begin
      #1;
      checkOutput("fx_idle", 64'(busyf), 64'(0));
      applyStimulus();
      #1;
      checkOutput("fx_grant1", 64'(gntf), 64'(1));
      applyStimulus();
    end
    reqf[1] = '0;
    applyStimulus();
    #1;
    checkOutput("fx_grant3", 64'(gntf), 64'(3));
    checkOutput("fx_busy3",  64'(busyf), 64'(1));
    applyStimulus();
    reqf = '0;
    orespf = '0;

    // Round-robin fairness with all four channels requesting single beats
    req4[0] = mkreq(32'h0000_0000, 8'd0);
    req4[1] = mkreq(32'h0000_0010, 8'd0);
    req4[2] = mkreq(32'h0000_0020, 8'd0);
    req4[3] = mkreq(32'h0000_0030, 8'd0);
    oresp4  = mkresp(1'b1, 1'b1, 32'h1111_0000);
    for (int n = 0; n < 5; n++) begin
      #1;
      checkOutput("rr_bubble", 64'(busy4), 64'(0));
      applyStimulus();
      #1;
      checkOutput("rr_order", 64'(gnt4), 64'(exp_rr[n]));
      applyStimulus();
    end

    // Burst hold: channel 0 four beats while channel 1 waits (rr_ptr is 1 here)
    req4    = '0;
    req4[0] = mkreq(32'h0000_1000, 8'd3);
    oresp4  = '0;
    #1;
    checkOutput("bu_idle", 64'(busy4), 64'(0));
    applyStimulus();
    req4[1] = mkreq(32'h0000_2000, 8'd0);
    for (int b = 0; b < 4; b++) begin
      oresp4 = mkresp(1'b1, (b == 3), 32'h2000_0000 + 32'(b));
      #1;
      checkOutput("bu_grant",   64'(gnt4), 64'(0));
      checkOutput("bu_busy",    64'(busy4), 64'(1));
      checkOutput("bu_rdy0",    64'(resp4[0].ready), 64'(1));
      checkOutput("bu_resp1_0", 64'(resp4[1]), 64'(0));
      applyStimulus();
    end
    req4[0] = '0;
    oresp4  = mkresp(1'b1, 1'b1, 32'h3333_0000);
    #1;
    checkOutput("bu_release",   64'(busy4), 64'(0));
    checkOutput("bu_resp1_idl", 64'(resp4[1]), 64'(0));
    applyStimulus();
    #1;
    checkOutput("bu_grant1",    64'(gnt4), 64'(1));
    checkOutput("bu_rdy1",      64'(resp4[1].ready), 64'(1));
    applyStimulus();

    // Abandonment: channel 2 drops valid after beat 1 (rr_ptr is 2 here)
    req4[1] = '0;
    req4[2] = mkreq(32'h0000_3000, 8'd3);
    req4[3] = mkreq(32'h0000_4000, 8'd3);
    oresp4  = mkresp(1'b1, 1'b0, 32'h4444_0000);
    #1;
    checkOutput("ab_idle", 64'(busy4), 64'(0));
    applyStimulus();
    #1;
    checkOutput("ab_grant2", 64'(gnt4), 64'(2));
    checkOutput("ab_noerr",  64'(err4), 64'(0));
    applyStimulus();
    req4[2].valid = 1'b0;
    oresp4 = '0;
    #1;
    checkOutput("ab_perr",     64'(err4), 64'(1));
    checkOutput("ab_oreq_vld", 64'(oreq4.valid), 64'(0));
    applyStimulus();
    #1;
    checkOutput("ab_busy_off", 64'(busy4), 64'(0));
    checkOutput("ab_perr_off", 64'(err4), 64'(0));
    applyStimulus();
    oresp4 = mkresp(1'b1, 1'b0, 32'h5555_0000);
    #1;
    checkOutput("ab_grant3", 64'(gnt4), 64'(3));
    checkOutput("ab_busy3",  64'(busy4), 64'(1));
    applyStimulus();

    // Reset during beat 2 of channel 3's burst (rr_ptr is 3 before reset)
    reset = 1'b0;
    #1;
    checkOutput("rm_oreq_vld", 64'(oreq4.valid), 64'(0));
    checkOutput("rm_perr",     64'(err4), 64'(0));
    checkOutput("rm_busy",     64'(busy4), 64'(0));
    applyStimulus();
    reset   = 1'b1;
    req4[0] = mkreq(32'h0000_0000, 8'd0);
    req4[1] = mkreq(32'h0000_0010, 8'd0);
    req4[2] = mkreq(32'h0000_0020, 8'd0);
    req4[3] = mkreq(32'h0000_0030, 8'd0);
    oresp4  = mkresp(1'b1, 1'b1, 32'h0);
    #1;
    checkOutput("rm_after_busy",  64'(busy4), 64'(0));
    checkOutput("rm_after_grant", 64'(gnt4), 64'(0));
    checkOutput("rm_after_perr",  64'(err4), 64'(0));
    applyStimulus();
    #1;
    checkOutput("rm_ptr_zero", 64'(gnt4), 64'(0));
    applyStimulus();
    req4 = '0;
    oresp4 = '0;
    applyStimulus();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
